// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI mode-0 initiator that issues READ (0x03) plus a 24-bit address
// and streams the returned bytes out on a valid/ready interface with backpressure.
module spi_flash_reader #(
    parameter int CLK_DIV = 4,
    parameter int LENW    = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [23:0]     req_addr,
    input  logic [LENW-1:0] req_len,
    output logic [7:0]      rd_data,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic            busy,
    output logic            done,
    output logic            spi_sck,
    output logic            spi_cs,
    output logic            spi_mosi,
    input  logic            spi_miso
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT_CA, DATA_WAIT, DATA, CS_HOLD, FINISH} state_t;

    state_t          state;
    logic [DW-1:0]   div;
    logic [4:0]      bit_cnt;
    logic [LENW-1:0] remaining;
    logic [31:0]     tx_sr;
    logic [7:0]      rx_sr;
    logic            tick;
    logic            slot_free;
    logic            last_bit;

    assign req_ready = state == IDLE;
    assign spi_mosi  = tx_sr[31];
    assign tick      = div == DIV_MAX;
    assign slot_free = !rd_valid || rd_ready;
    assign last_bit  = bit_cnt == (state == SHIFT_CA ? 5'd31 : 5'd7);

    // Each SCK period is a low half then a high half; DATA_WAIT owns the low half
    // of a byte's first bit so it can stall there while the output slot is full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            div       <= '0;
            bit_cnt   <= '0;
            remaining <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            spi_sck   <= 1'b0;
            spi_cs    <= 1'b1;
        end else begin
            done <= 1'b0;
            if (rd_valid && rd_ready)
                rd_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    tx_sr     <= {8'h03, req_addr};
                    remaining <= req_len;
                    busy      <= 1'b1;
                    div       <= '0;
                    bit_cnt   <= '0;
                    if (req_len == '0) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        state  <= CS_SETUP;
                        spi_cs <= 1'b0;
                    end
                end
                CS_SETUP: begin
                    div <= tick ? '0 : div + 1'b1;
                    if (tick)
                        state <= SHIFT_CA;
                end
                SHIFT_CA, DATA: begin
                    div <= tick ? '0 : div + 1'b1;
                    if (tick && !spi_sck) begin
                        spi_sck <= 1'b1;
                        rx_sr   <= {rx_sr[6:0], spi_miso};
                    end else if (tick) begin
                        spi_sck <= 1'b0;
                        tx_sr   <= {tx_sr[30:0], 1'b0};
                        bit_cnt <= last_bit ? 5'd0 : bit_cnt + 5'd1;
                        if (last_bit && state == SHIFT_CA) begin
                            state <= DATA_WAIT;
                        end else if (last_bit) begin
                            rd_data   <= rx_sr;
                            rd_valid  <= 1'b1;
                            remaining <= remaining - 1'b1;
                            state     <= remaining == LENW'(1) ? CS_HOLD : DATA_WAIT;
                        end
                    end
                end
                DATA_WAIT: begin
                    if (!tick) begin
                        div <= div + 1'b1;
                    end else if (slot_free) begin
                        div     <= '0;
                        spi_sck <= 1'b1;
                        rx_sr   <= {rx_sr[6:0], spi_miso};
                        state   <= DATA;
                    end
                end
                CS_HOLD: if (slot_free) begin
                    div <= tick ? '0 : div + 1'b1;
                    if (tick) begin
                        spi_cs <= 1'b1;
                        state  <= FINISH;
                        done   <= 1'b1;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: directed bench with three readers (CLK_DIV 2, 1, 4) and a mode-0 flash model.
module tb_spi_flash_reader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid [3];
    logic        req_ready [3];
    logic [23:0] req_addr  [3];
    logic [15:0] req_len   [3];
    logic [7:0]  rd_data   [3];
    logic        rd_valid  [3];
    logic        rd_ready  [3];
    logic        busy      [3];
    logic        done      [3];
    logic        sck       [3];
    logic        cs        [3];
    logic        mosi      [3];
    logic        miso      [3] = '{default: 1'b0};
    logic [7:0]  fdata     [3][4];

    int          rises    [3] = '{default: 0};
    int          total    [3] = '{default: 0};
    logic [31:0] cmd      [3] = '{default: 32'h0};
    logic        psck     [3] = '{default: 1'b0};
    logic        pcs      [3] = '{default: 1'b1};
    int          nacc     [3] = '{default: 0};
    logic [7:0]  acc      [3][8];
    int          ndone    [3] = '{default: 0};
    int          low_run  [3] = '{default: 0};
    int          last_low [3] = '{default: 0};

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : f
        spi_flash_reader #(.CLK_DIV(g == 0 ? 2 : (g == 1 ? 1 : 4)), .LENW(16)) dut (
            .clk(clk), .reset(reset),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_addr(req_addr[g]), .req_len(req_len[g]),
            .rd_data(rd_data[g]), .rd_valid(rd_valid[g]), .rd_ready(rd_ready[g]),
            .busy(busy[g]), .done(done[g]),
            .spi_sck(sck[g]), .spi_cs(cs[g]), .spi_mosi(mosi[g]), .spi_miso(miso[g])
        );
    end

    // Flash model: captures the first 32 MOSI bits on SCK rise, shifts data out after each fall.
    always @(negedge clk) begin : model
        int k;
        for (int g = 0; g < 3; g++) begin
            if (!cs[g] && pcs[g]) begin
                rises[g] <= 0;
                cmd[g]   <= '0;
            end else if (sck[g] && !psck[g]) begin
                rises[g] <= rises[g] + 1;
                total[g] <= total[g] + 1;
                if (rises[g] < 32)
                    cmd[g] <= {cmd[g][30:0], mosi[g]};
            end else if (!sck[g] && psck[g] && rises[g] >= 32) begin
                k = rises[g] - 32;
                miso[g] <= fdata[g][(k / 8) % 4][7 - k % 8];
            end
            psck[g] <= sck[g];
            pcs[g]  <= cs[g];
        end
    end

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rd_valid[g] && rd_ready[g]) begin
                acc[g][nacc[g] % 8] <= rd_data[g];
                nacc[g] <= nacc[g] + 1;
            end
            if (done[g])
                ndone[g] <= ndone[g] + 1;
            if (!cs[g]) begin
                low_run[g] <= low_run[g] + 1;
            end else if (low_run[g] != 0) begin
                last_low[g] <= low_run[g];
                low_run[g]  <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic launch(input int g, input logic [23:0] addr, input logic [15:0] len);
        @(negedge clk);
        req_addr[g]  = addr;
        req_len[g]   = len;
        req_valid[g] = 1'b1;
        @(negedge clk);
        req_valid[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g, input string tag);
        for (int i = 0; i < 4000 && busy[g]; i++)
            @(negedge clk);
        check({tag, "_timeout"}, busy[g], 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, d, t, hi, bad, falls, gap, run, hp;
        logic prev;
        for (int g = 0; g < 3; g++) begin
            req_valid[g] = 1'b0;
            req_addr[g]  = '0;
            req_len[g]   = '0;
            rd_ready[g]  = 1'b1;
            for (int i = 0; i < 4; i++)
                fdata[g][i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check("rst_cs", cs[0], 1'b1);
        check("rst_sck", sck[0], 1'b0);
        check("rst_mosi", mosi[0], 1'b0);
        check("rst_rd_valid", rd_valid[0], 1'b0);
        check("rst_rd_data", rd_data[0], 8'h00);
        check("rst_done", done[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", req_ready[0], 1'b1);

        // Basic read, CLK_DIV=2
        fdata[0][0] = 8'hA5;
        fdata[0][1] = 8'h3C;
        base = nacc[0];
        d = ndone[0];
        launch(0, 24'h012345, 16'd2);
        wait_idle(0, "t1");
        check("t1_cmd", cmd[0], 32'h03012345);
        check("t1_rises", rises[0], 48);
        check("t1_count", nacc[0] - base, 2);
        check("t1_byte0", acc[0][base % 8], 8'hA5);
        check("t1_byte1", acc[0][(base + 1) % 8], 8'h3C);
        check("t1_cs_low", last_low[0], 196);
        check("t1_done", ndone[0] - d, 1);

        // Zero-length request
        t = total[0];
        @(negedge clk);
        req_addr[0]  = 24'h000100;
        req_len[0]   = 16'd0;
        req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("z_busy", busy[0], 1'b1);
        check("z_done", done[0], 1'b1);
        check("z_cs", cs[0], 1'b1);
        @(negedge clk);
        check("z_busy_end", busy[0], 1'b0);
        check("z_done_end", done[0], 1'b0);
        check("z_cs_end", cs[0], 1'b1);
        check("z_sck", total[0] - t, 0);

        // Backpressure, CLK_DIV=1
        fdata[1][0] = 8'h11;
        fdata[1][1] = 8'h22;
        fdata[1][2] = 8'h33;
        rd_ready[1] = 1'b0;
        base = nacc[1];
        launch(1, 24'h000010, 16'd3);
        for (int i = 0; i < 2000 && !rd_valid[1]; i++)
            @(negedge clk);
        check("bp_first_valid", rd_valid[1], 1'b1);
        check("bp_first", rd_data[1], 8'h11);
        t = total[1];
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (sck[1])
                hi++;
        end
        check("bp_sck_low", hi, 0);
        check("bp_hold_data", rd_data[1], 8'h11);
        check("bp_hold_valid", rd_valid[1], 1'b1);
        check("bp_no_edges", total[1] - t, 0);
        rd_ready[1] = 1'b1;
        wait_idle(1, "bp");
        check("bp_count", nacc[1] - base, 3);
        check("bp_byte0", acc[1][base % 8], 8'h11);
        check("bp_byte1", acc[1][(base + 1) % 8], 8'h22);
        check("bp_byte2", acc[1][(base + 2) % 8], 8'h33);
        check("bp_rises", rises[1], 56);

        // Asynchronous reset mid-address
        d = ndone[0];
        launch(0, 24'h123456, 16'd4);
        for (int i = 0; i < 2000 && rises[0] < 18; i++)
            @(negedge clk);
        reset = 1'b1;
        #1;
        check("ar_cs", cs[0], 1'b1);
        check("ar_sck", sck[0], 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("ar_no_done", ndone[0] - d, 0);
        check("ar_busy", busy[0], 1'b0);
        fdata[0][0] = 8'hFF;
        base = nacc[0];
        launch(0, 24'h000000, 16'd1);
        wait_idle(0, "ar");
        check("ar_cmd", cmd[0], 32'h03000000);
        check("ar_count", nacc[0] - base, 1);
        check("ar_data", acc[0][base % 8], 8'hFF);
        check("ar_rises", rises[0], 40);

        // req_valid held high: two back-to-back transfers
        fdata[0][0] = 8'h5A;
        base = nacc[0];
        d = ndone[0];
        @(negedge clk);
        req_addr[0]  = 24'h000200;
        req_len[0]   = 16'd1;
        req_valid[0] = 1'b1;
        bad = 0;
        falls = 0;
        gap = 1000;
        hi = 0;
        prev = 1'b1;
        for (int i = 0; i < 3000 && ndone[0] - d < 2; i++) begin
            @(negedge clk);
            if (busy[0] && req_ready[0])
                bad++;
            if (!cs[0] && prev) begin
                falls++;
                if (falls > 1 && hi < gap)
                    gap = hi;
            end
            hi = cs[0] ? hi + 1 : 0;
            prev = cs[0];
        end
        req_valid[0] = 1'b0;
        check("bb_done", ndone[0] - d, 2);
        check("bb_cs_falls", falls, 2);
        check("bb_gap_ge1", gap >= 1, 1'b1);
        check("bb_ready_low", bad, 0);
        check("bb_count", nacc[0] - base, 2);
        wait_idle(0, "bb");

        // Half-period and MSB-first sampling, CLK_DIV=4
        fdata[2][0] = 8'h80;
        base = nacc[2];
        launch(2, 24'h000ABC, 16'd1);
        hp = 0;
        run = 0;
        for (int i = 0; i < 2000 && busy[2]; i++) begin
            @(negedge clk);
            if (sck[2]) begin
                run++;
            end else begin
                if (run > 0 && hp == 0)
                    hp = run;
                run = 0;
            end
        end
        check("hp_timeout", busy[2], 1'b0);
        @(negedge clk);
        check("hp_half_period", hp, 4);
        check("hp_data", acc[2][base % 8], 8'h80);
        check("hp_rises", rises[2], 40);
        check("hp_cs_low", last_low[2], 328);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
